// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target receiver state encoding, default address, ACK levels.
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        DATA,
        ACK_D,
        IGNORE
    } state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h27;
    localparam logic       ACK              = 1'b0;
    localparam logic       NACK             = 1'b1;
endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one raw bus pin, with registered previous sample for edge detection.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Reset to 1 so an idle-high bus produces no edge when reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/i2c_target_rx.sv
// I2C target write receiver: START/STOP detection, address match, ACK drive and byte output.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);
    logic       scl_lvl, scl_rise, scl_fall;
    logic       sda_lvl, sda_rise, sda_fall;
    logic       scl_stable_high, start_ev, stop_ev;
    logic [7:0] shifted;
    logic [6:0] shreg;
    logic [2:0] cnt;
    logic       ack_phase;
    state_t     state;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .din   (scl_in),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // SCL high in both samples; a simultaneous SCL edge makes it a data transition.
    assign scl_stable_high = scl_lvl & ~scl_rise;
    assign start_ev        = scl_stable_high & sda_fall;
    assign stop_ev         = scl_stable_high & sda_rise;
    assign shifted         = {shreg, sda_lvl};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= 3'd7;
            ack_phase <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            addr_hit  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            if (stop_ev) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                addr_hit <= 1'b0;
                busy     <= 1'b0;
                stop_det <= 1'b1;
            end else if (start_ev) begin
                state     <= ADDR;
                cnt       <= 3'd7;
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                addr_hit  <= 1'b0;
                busy      <= 1'b1;
                start_det <= 1'b1;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg <= shifted[6:0];
                        if (cnt == 3'd0) begin
                            if (shifted[7:1] == DEV_ADDR && !shifted[0]) begin
                                state     <= ACK_A;
                                addr_hit  <= 1'b1;
                                ack_phase <= 1'b0;
                            end else begin
                                state <= IGNORE;
                            end
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    DATA: if (scl_rise) begin
                        shreg <= shifted[6:0];
                        if (cnt == 3'd0) begin
                            rx_data   <= shifted;
                            rx_valid  <= 1'b1;
                            state     <= ACK_D;
                            ack_phase <= 1'b0;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    // First fall drives the ACK slot, second fall releases it.
                    ACK_A, ACK_D: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            sda_oe    <= 1'b0;
                            ack_phase <= 1'b0;
                            cnt       <= 3'd7;
                            state     <= DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged I2C master with open-drain SDA model.
module tb_i2c_target_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, addr_hit, start_det, stop_det, busy;

    int tests = 0;
    int failed = 0;
    int n_valid = 0, n_start = 0, n_stop = 0, n_oe_rise = 0, n_wide = 0;
    logic prev_valid = 1'b0, prev_oe = 1'b0;
    logic [7:0] hist[$];
    logic lat_pre, lat_at;
    logic ack;
    int b_valid, b_start, b_stop, b_oe, b_hist;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.DEV_ADDR(7'h27), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_hit  (addr_hit),
        .start_det (start_det),
        .stop_det  (stop_det),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            hist.push_back(rx_data);
        end
        if (rx_valid && prev_valid) n_wide++;
        if (start_det) n_start++;
        if (stop_det) n_stop++;
        if (sda_oe && !prev_oe) n_oe_rise++;
        prev_valid = rx_valid;
        prev_oe    = sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_valid = n_valid; b_start = n_start; b_stop = n_stop;
        b_oe = n_oe_rise; b_hist = hist.size();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(10);
        scl = 1'b1;   wait_clk(10);
        sda_m = 1'b0; wait_clk(10);
        scl = 1'b0;   wait_clk(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(10);
        scl = 1'b1;   wait_clk(10);
        sda_m = 1'b1; wait_clk(10);
    endtask

    task automatic send_bit(input logic b, input logic is_lsb);
        sda_m = b; wait_clk(5);
        scl = 1'b1;
        if (is_lsb) begin
            wait_clk(2); lat_pre = rx_valid;
            wait_clk(1); lat_at = rx_valid;
            wait_clk(7);
        end else begin
            wait_clk(10);
        end
        scl = 1'b0; wait_clk(5);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(v[i], i == 0);
        sda_m = 1'b1; wait_clk(5);
        scl = 1'b1;   wait_clk(5);
        a = sda_line; wait_clk(5);
        scl = 1'b0;   wait_clk(5);
    endtask

    initial begin
        wait_clk(4);
        check("reset_sda_oe", sda_oe, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_addr_hit", addr_hit, 0);
        reset = 1'b0;
        wait_clk(10);

        // 1: single byte to our address
        snap();
        i2c_start();
        check("t1_busy", busy, 1);
        write_byte(8'h4E, ack);
        check("t1_addr_ack", ack, 0);
        check("t1_addr_hit", addr_hit, 1);
        write_byte(8'hA5, ack);
        check("t1_lat_pre", lat_pre, 0);
        check("t1_lat_at", lat_at, 1);
        check("t1_data_ack", ack, 0);
        i2c_stop();
        wait_clk(5);
        check("t1_rx_data", rx_data, 8'hA5);
        check("t1_valid_cnt", n_valid - b_valid, 1);
        check("t1_start_cnt", n_start - b_start, 1);
        check("t1_stop_cnt", n_stop - b_stop, 1);
        check("t1_oe_rises", n_oe_rise - b_oe, 2);
        check("t1_busy_end", busy, 0);
        check("t1_addr_hit_end", addr_hit, 0);

        // 2: wrong address
        snap();
        check("t2_busy_pre", busy, 0);
        i2c_start();
        check("t2_busy", busy, 1);
        write_byte(8'h50, ack);
        check("t2_addr_nack", ack, 1);
        check("t2_addr_hit", addr_hit, 0);
        write_byte(8'h5A, ack);
        check("t2_data_nack", ack, 1);
        i2c_stop();
        wait_clk(5);
        check("t2_busy_end", busy, 0);
        check("t2_valid_cnt", n_valid - b_valid, 0);
        check("t2_oe_rises", n_oe_rise - b_oe, 0);
        check("t2_rx_hold", rx_data, 8'hA5);

        // 3: two bytes
        snap();
        i2c_start();
        write_byte(8'h4E, ack);
        check("t3_addr_ack", ack, 0);
        write_byte(8'h12, ack);
        check("t3_d0_ack", ack, 0);
        write_byte(8'h34, ack);
        check("t3_d1_ack", ack, 0);
        i2c_stop();
        wait_clk(5);
        check("t3_valid_cnt", n_valid - b_valid, 2);
        check("t3_hist_len", hist.size() - b_hist, 2);
        if (hist.size() >= b_hist + 2) begin
            check("t3_first", hist[b_hist], 8'h12);
            check("t3_second", hist[b_hist + 1], 8'h34);
        end
        check("t3_oe_rises", n_oe_rise - b_oe, 3);

        // 4: partial byte then repeated START
        snap();
        i2c_start();
        write_byte(8'h4E, ack);
        check("t4_addr_ack", ack, 0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        i2c_start();
        check("t4_rs_busy", busy, 1);
        check("t4_rs_addr_hit", addr_hit, 0);
        check("t4_partial_valid", n_valid - b_valid, 0);
        write_byte(8'h4E, ack);
        check("t4_addr2_ack", ack, 0);
        write_byte(8'hC3, ack);
        i2c_stop();
        wait_clk(5);
        check("t4_rx_data", rx_data, 8'hC3);
        check("t4_valid_cnt", n_valid - b_valid, 1);
        check("t4_start_cnt", n_start - b_start, 2);

        // 5: read request is NACKed and ignored
        snap();
        i2c_start();
        write_byte(8'h4F, ack);
        check("t5_read_nack", ack, 1);
        check("t5_addr_hit", addr_hit, 0);
        write_byte(8'h4E, ack);
        check("t5_ignored_nack", ack, 1);
        check("t5_busy", busy, 1);
        i2c_stop();
        wait_clk(5);
        check("t5_valid_cnt", n_valid - b_valid, 0);
        check("t5_oe_rises", n_oe_rise - b_oe, 0);

        // 6: reset during data ACK
        i2c_start();
        write_byte(8'h4E, ack);
        for (int i = 7; i >= 0; i--) send_bit(1'b0, 1'b0);
        sda_m = 1'b1; wait_clk(5);
        check("t6_oe_in_ack", sda_oe, 1);
        reset = 1'b1; wait_clk(1);
        check("t6_oe_after_rst", sda_oe, 0);
        check("t6_busy_after_rst", busy, 0);
        check("t6_hit_after_rst", addr_hit, 0);
        check("t6_data_after_rst", rx_data, 0);
        reset = 1'b0; wait_clk(5);
        snap();
        write_byte(8'h4E, ack);
        check("t6_no_start_nack", ack, 1);
        check("t6_no_start_busy", busy, 0);
        check("t6_no_start_oe", n_oe_rise - b_oe, 0);
        i2c_stop();
        i2c_start();
        write_byte(8'h4E, ack);
        check("t6_addr_ack", ack, 0);
        write_byte(8'hFF, ack);
        check("t6_data_ack", ack, 0);
        i2c_stop();
        wait_clk(5);
        check("t6_rx_data", rx_data, 8'hFF);
        check("t6_valid_cnt", n_valid - b_valid, 1);

        check("valid_pulse_width", n_wide, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
